// File: rtl/decode_stage.sv
// Decode stage: splits the IF_ID word, reads a 32x32 register file with writeback
// bypass, detects load-use hazards and registers the decoded result into ID_EX.
module decode_stage #(
   parameter int         NUM_REGS = 32,
   parameter logic [5:0] OP_RTYPE = 6'h00,
   parameter logic [5:0] OP_ADDI  = 6'h08,
   parameter logic [5:0] OP_LW    = 6'h23,
   parameter logic [5:0] OP_SW    = 6'h2B,
   parameter logic [5:0] OP_BEQ   = 6'h04
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] IF_ID,
   input  logic        if_valid,
   input  logic        ex_stall,
   input  logic        wb_en,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        stall_fetch,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_pc,
   output logic [5:0]  id_ex_opcode,
   output logic [31:0] id_ex_rs_data,
   output logic [31:0] id_ex_rt_data,
   output logic [31:0] id_ex_imm,
   output logic [4:0]  id_ex_dest,
   output logic        id_ex_reg_write,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic        id_ex_illegal
);

   // Handshake: an instruction in IF_ID is consumed on a posedge only when if_valid=1
   // and stall_fetch=0; while stall_fetch=1 fetch holds pc/IF_ID. ID_EX is offered to
   // execute with id_ex_valid and is frozen for every cycle that ex_stall=1.

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  opcode;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  dest;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        illegal;
   } id_ex_t;

   logic [31:0] regs_q [NUM_REGS];
   id_ex_t      id_ex_q, id_ex_d, dec;

   logic [31:0] pc;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic [31:0] rs_val, rt_val;
   logic        uses_rt;
   logic        hazard;

   assign pc    = IF_ID[63:32];
   assign instr = IF_ID[31:0];
   assign op    = instr[31:26];
   assign rs    = instr[25:21];
   assign rt    = instr[20:16];
   assign rd    = instr[15:11];
   assign imm16 = instr[15:0];

   // r0 is hard-wired; a same-cycle writeback is forwarded so decode never sees stale data.
   assign rs_val = (rs == 5'd0) ? 32'd0 :
                   (wb_en && wb_addr == rs) ? wb_data : regs_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 :
                   (wb_en && wb_addr == rt) ? wb_data : regs_q[rt];

   assign uses_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);

   assign hazard = if_valid && id_ex_q.valid && id_ex_q.mem_read &&
                   (id_ex_q.dest != 5'd0) &&
                   ((id_ex_q.dest == rs) || (uses_rt && id_ex_q.dest == rt));

   assign stall_fetch = ex_stall || hazard;

   always_comb begin
      dec           = '0;
      dec.valid     = 1'b1;
      dec.pc        = pc;
      dec.opcode    = op;
      dec.rs_data   = rs_val;
      dec.rt_data   = rt_val;
      dec.imm       = {{16{imm16[15]}}, imm16};
      case (op)
         OP_RTYPE: begin
            dec.dest      = rd;
            dec.reg_write = 1'b1;
         end
         OP_ADDI: begin
            dec.dest      = rt;
            dec.reg_write = 1'b1;
         end
         OP_LW: begin
            dec.dest      = rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
         end
         OP_SW:   dec.mem_write = 1'b1;
         OP_BEQ:  ;
         default: dec.illegal = 1'b1;
      endcase
   end

   // Bubbles clear the whole ID_EX word so nothing stale leaks into execute.
   always_comb begin
      id_ex_d = id_ex_q;
      if (ex_stall)
         id_ex_d = id_ex_q;
      else if (hazard || !if_valid)
         id_ex_d = '0;
      else
         id_ex_d = dec;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_ex_q <= '0;
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else begin
         id_ex_q <= id_ex_d;
         if (wb_en && wb_addr != 5'd0)
            regs_q[wb_addr] <= wb_data;
      end
   end

   assign id_ex_valid     = id_ex_q.valid;
   assign id_ex_pc        = id_ex_q.pc;
   assign id_ex_opcode    = id_ex_q.opcode;
   assign id_ex_rs_data   = id_ex_q.rs_data;
   assign id_ex_rt_data   = id_ex_q.rt_data;
   assign id_ex_imm       = id_ex_q.imm;
   assign id_ex_dest      = id_ex_q.dest;
   assign id_ex_reg_write = id_ex_q.reg_write;
   assign id_ex_mem_read  = id_ex_q.mem_read;
   assign id_ex_mem_write = id_ex_q.mem_write;
   assign id_ex_illegal   = id_ex_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of fetch.
- Consumes the 64-bit IF_ID word: [63:32] = pc, [31:0] = instruction.
- Decodes the instruction, reads a 32x32 register file that has a writeback write port, and sign-extends the immediate.
- Detects load-use hazards and launches the result into the registered ID_EX outputs for execute. Upstream and downstream stalls are handled with a simple valid/stall handshake.

Parameters:
- NUM_REGS, 32, register file depth; address width fixed at 5.
- OP_RTYPE, 6'h00, ALU register-register opcode.
- OP_ADDI, 6'h08, add-immediate opcode.
- OP_LW, 6'h23, load-word opcode.
- OP_SW, 6'h2B, store-word opcode.
- OP_BEQ, 6'h04, branch-equal opcode.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- IF_ID  in  64  fetch output; [63:32] pc, [31:0] instruction
- if_valid  in  1  IF_ID holds a real instruction this cycle
- ex_stall  in  1  execute cannot accept; ID_EX must hold
- wb_en  in  1  writeback write enable
- wb_addr  in  5  writeback register index
- wb_data  in  32  writeback data
- stall_fetch  out  1  combinational; fetch must hold pc and IF_ID
- id_ex_valid  out  1  ID_EX contents valid
- id_ex_pc  out  32  pc of the decoded instruction
- id_ex_opcode  out  6  instruction[31:26]
- id_ex_rs_data  out  32  operand A
- id_ex_rt_data  out  32  operand B
- id_ex_imm  out  32  sign-extended instruction[15:0]
- id_ex_dest  out  5  destination register, 0 if none
- id_ex_reg_write  out  1  instruction writes a register
- id_ex_mem_read  out  1  load
- id_ex_mem_write  out  1  store
- id_ex_illegal  out  1  unknown opcode

Behaviour:
- Fields: op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0].
- Destination and write flag:
  - RTYPE: dest = rd, reg_write = 1.
  - ADDI and LW: dest = rt, reg_write = 1. LW also sets mem_read = 1.
  - SW: dest = 0, reg_write = 0, mem_write = 1.
  - BEQ: dest = 0, reg_write = 0.
  - Any other opcode: illegal = 1, dest = 0, reg_write = 0, mem_read = 0, mem_write = 0; still passes as valid.
- uses_rt = 1 for RTYPE, SW and BEQ.
- Register file:
  - Writes at posedge when wb_en = 1 and wb_addr != 0.
  - r0 always reads 0.
  - Reads are combinational with write-through bypass: if wb_en, wb_addr == read index and index != 0, return wb_data.
- Load-use hazard (combinational), all of the following:
  - if_valid
  - id_ex_valid and id_ex_mem_read
  - id_ex_dest != 0
  - id_ex_dest == rs, or (uses_rt and id_ex_dest == rt)
- stall_fetch = ex_stall OR hazard.
- Per posedge, in priority order:
  1. ex_stall = 1: every ID_EX output holds.
  2. hazard = 1: bubble; id_ex_valid <= 0, all control flags <= 0. The instruction is re-decoded next cycle, since fetch holds it.
  3. if_valid = 0: id_ex_valid <= 0, control flags <= 0.
  4. Otherwise load every ID_EX field from the decode; id_ex_valid <= 1.
- Latency: one cycle from IF_ID to ID_EX. A load-use pair adds exactly one bubble.
- Reset, asserted at any time, asynchronously:
  - All ID_EX outputs go to 0, including id_ex_valid.
  - All 32 registers go to 0.
  - stall_fetch therefore drops to ex_stall.
  - The first decode occurs on the first posedge after reset deasserts.
- Simultaneous writeback and decode of the same register: decode sees wb_data through the bypass.
- A write to r0 is ignored, and a hazard on dest 0 is never raised.

Test Plan:
- Reset, then wb writes r1 = 32'h00000005 and r2 = 32'h00000007; IF_ID = {32'h0, RTYPE rs=1 rt=2 rd=3} with if_valid=1 -> next cycle id_ex_valid=1, rs_data=5, rt_data=7, dest=3, reg_write=1, pc=0.
- ADDI rt=4 imm=16'hFFFC -> id_ex_imm=32'hFFFFFFFC, dest=4. LW then immediately RTYPE reading the load's rt -> stall_fetch=1 for one cycle, one bubble (id_ex_valid=0), then the RTYPE issues with id_ex_valid=1.
- Bypass and r0: wb_en=1, wb_addr=9, wb_data=32'hDEADBEEF in the same cycle as decoding rs=9 -> id_ex_rs_data=32'hDEADBEEF. A write to r0 followed by a read of r0 -> 0.
- ex_stall held 3 cycles while IF_ID changes -> ID_EX is unchanged and stall_fetch=1 throughout. When ex_stall is released, the new instruction loads.
- Opcode 6'h3F -> id_ex_illegal=1, reg_write=0, valid=1. if_valid=0 -> id_ex_valid=0 next cycle.
- Assert reset mid-stream between clock edges -> outputs go to 0 immediately without waiting for a clock edge. A register read after release returns 0.
